// File: rtl/btle_ll_hci_if.sv
// Byte-stream link between the HCI engine and the UART framer pair.
// The master side is the host/UART side; the slave side is the HCI engine.
interface btle_ll_hci_if;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_err;
    logic [7:0] out_byte;
    logic       out_en;
    logic       out_done;

    modport master (output in_byte, in_valid, in_err, out_done, input out_byte, out_en);
    modport slave  (input in_byte, in_valid, in_err, out_done, output out_byte, out_en);
endinterface

// File: rtl/btle_ll_hci.sv
// BTLE link-layer HCI engine: parses host commands into PHY config and TX PDU memory,
// answers each command with a status response and streams received PDUs as events.
module btle_ll_hci #(
    parameter int PDU_ADDR_WIDTH           = 6,
    parameter int CRC_STATE_BIT_WIDTH      = 24,
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int TIMEOUT_CYCLES           = 16000
) (
    input  logic                                clk,
    input  logic                                rst,
    btle_ll_hci_if.slave                        hci,
    output logic [7:0]                          tx_preamble,
    output logic [31:0]                         tx_access_address,
    output logic [CRC_STATE_BIT_WIDTH-1:0]      tx_crc_state_init_bit,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] tx_channel_number,
    output logic [PDU_ADDR_WIDTH-1:0]           tx_pdu_octet_mem_addr,
    output logic [7:0]                          tx_pdu_octet_mem_data,
    output logic                                tx_pdu_octet_mem_we,
    output logic                                tx_start,
    output logic [31:0]                         rx_unique_bit_sequence,
    output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] rx_channel_number,
    output logic [CRC_STATE_BIT_WIDTH-1:0]      rx_crc_state_init_bit,
    input  logic                                rx_decode_end,
    input  logic                                rx_crc_ok,
    input  logic [6:0]                          rx_payload_length,
    output logic [PDU_ADDR_WIDTH-1:0]           rx_pdu_octet_mem_addr,
    input  logic [7:0]                          rx_pdu_octet_mem_data,
    output logic [7:0]                          evt_drop_cnt
);
    localparam int PDU_DEPTH = 2**PDU_ADDR_WIDTH;
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PAW       = PDU_ADDR_WIDTH;
    localparam int CRCW      = CRC_STATE_BIT_WIDTH;
    localparam int CHW       = CHANNEL_NUMBER_BIT_WIDTH;

    typedef enum logic [2:0] {P_IDLE, P_LEN, P_PAYLOAD, P_EXEC, P_RESP} pstate_t;
    typedef enum logic [1:0] {O_IDLE, O_MEM, O_LOAD, O_WAIT} ostate_t;

    pstate_t pstate_reg, pstate_next;
    ostate_t ostate_reg, ostate_next;
    logic [7:0]     opcode_reg, opcode_next, len_reg, len_next, cnt_reg, cnt_next;
    logic [7:0]     status_reg, status_next, reg_addr_reg, reg_addr_next, reg_data_reg, reg_data_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic [7:0]     preamble_reg, preamble_next;
    logic [31:0]    tx_aa_reg, tx_aa_next, rx_aa_reg, rx_aa_next;
    logic [CRCW-1:0] tx_crc_reg, tx_crc_next, rx_crc_reg, rx_crc_next;
    logic [CHW-1:0] tx_ch_reg, tx_ch_next, rx_ch_reg, rx_ch_next;
    logic           we_reg, we_next;
    logic [PAW-1:0] waddr_reg, waddr_next, raddr_reg, raddr_next;
    logic [7:0]     wdata_reg, wdata_next, obyte_reg, obyte_next, oidx_reg, oidx_next;
    logic           osrc_reg, osrc_next, oen_reg, oen_next;
    logic           pend_reg, pend_next, evt_crc_reg, evt_crc_next;
    logic [6:0]     evt_len_reg, evt_len_next;
    logic [7:0]     drop_reg, drop_next;

    logic [7:0] idx_inc;
    logic [6:0] evt_nbytes;
    logic       out_last, evt_busy, resp_done;

    assign idx_inc    = oidx_reg + 8'd1;
    assign evt_nbytes = (int'(evt_len_reg) > PDU_DEPTH) ? 7'(PDU_DEPTH) : evt_len_reg;
    assign out_last   = osrc_reg ? (oidx_reg == ({1'b0, evt_nbytes} + 8'd1)) : (oidx_reg == 8'd1);
    assign evt_busy   = osrc_reg && (ostate_reg != O_IDLE);

    always_comb begin
        pstate_next = pstate_reg;   ostate_next = ostate_reg;
        opcode_next = opcode_reg;   len_next = len_reg;         cnt_next = cnt_reg;
        status_next = status_reg;   reg_addr_next = reg_addr_reg; reg_data_next = reg_data_reg;
        timer_next = timer_reg;     preamble_next = preamble_reg;
        tx_aa_next = tx_aa_reg;     tx_crc_next = tx_crc_reg;   tx_ch_next = tx_ch_reg;
        rx_aa_next = rx_aa_reg;     rx_crc_next = rx_crc_reg;   rx_ch_next = rx_ch_reg;
        we_next = 1'b0;             waddr_next = waddr_reg;     wdata_next = wdata_reg;
        raddr_next = raddr_reg;     obyte_next = obyte_reg;     oidx_next = oidx_reg;
        osrc_next = osrc_reg;       oen_next = 1'b0;            pend_next = pend_reg;
        evt_crc_next = evt_crc_reg; evt_len_next = evt_len_reg; drop_next = drop_reg;
        tx_start = 1'b0;            resp_done = 1'b0;

        case (ostate_reg)
            O_IDLE: begin
                // A waiting response always wins over a pending event.
                if (pstate_reg == P_RESP) begin
                    osrc_next = 1'b0; oidx_next = 8'd0; raddr_next = '0; ostate_next = O_MEM;
                end else if (pend_reg) begin
                    osrc_next = 1'b1; oidx_next = 8'd0; raddr_next = '0; ostate_next = O_MEM;
                    pend_next = 1'b0;
                end
            end
            O_MEM:  ostate_next = O_LOAD;
            O_LOAD: begin
                oen_next    = 1'b1;
                ostate_next = O_WAIT;
                if (oidx_reg == 8'd0)      obyte_next = osrc_reg ? 8'h3E : 8'h0E;
                else if (oidx_reg == 8'd1) obyte_next = osrc_reg ? {evt_crc_reg, evt_len_reg} : status_reg;
                else                       obyte_next = rx_pdu_octet_mem_data;
            end
            O_WAIT: begin
                if (hci.out_done) begin
                    if (out_last) begin
                        ostate_next = O_IDLE;
                        resp_done   = !osrc_reg;
                    end else begin
                        oidx_next   = idx_inc;
                        raddr_next  = (idx_inc >= 8'd2) ? PAW'(idx_inc - 8'd2) : '0;
                        ostate_next = O_MEM;
                    end
                end
            end
            default: ostate_next = O_IDLE;
        endcase

        if (rx_decode_end) begin
            if (pend_reg || evt_busy) begin
                if (drop_reg != 8'hFF) drop_next = drop_reg + 8'd1;
            end else begin
                pend_next = 1'b1; evt_crc_next = rx_crc_ok; evt_len_next = rx_payload_length;
            end
        end

        case (pstate_reg)
            P_IDLE: begin
                if (hci.in_valid) begin
                    opcode_next = hci.in_byte; timer_next = '0; pstate_next = P_LEN;
                end
            end
            P_LEN, P_PAYLOAD: begin
                timer_next = timer_reg + TW'(1);
                if (hci.in_err) begin
                    status_next = 8'd3; pstate_next = P_RESP;
                end else if (hci.in_valid) begin
                    timer_next = '0;
                    if (pstate_reg == P_LEN) begin
                        len_next = hci.in_byte;
                        cnt_next = 8'd0;
                        case (opcode_reg)
                            8'h01:   status_next = (hci.in_byte == 8'd2) ? 8'd0 : 8'd2;
                            8'h02:   status_next = (hci.in_byte == 8'd0 ||
                                                    {1'b0, hci.in_byte} > 9'(PDU_DEPTH)) ? 8'd2 : 8'd0;
                            8'h03:   status_next = (hci.in_byte == 8'd0) ? 8'd0 : 8'd2;
                            default: status_next = 8'd1;
                        endcase
                        pstate_next = (hci.in_byte == 8'd0) ? P_EXEC : P_PAYLOAD;
                    end else begin
                        // Payload of a rejected packet is swallowed so the stream stays aligned.
                        if (status_reg == 8'd0 && opcode_reg == 8'h01) begin
                            if (cnt_reg == 8'd0) reg_addr_next = hci.in_byte;
                            else                 reg_data_next = hci.in_byte;
                        end
                        if (status_reg == 8'd0 && opcode_reg == 8'h02) begin
                            we_next = 1'b1; waddr_next = cnt_reg[PAW-1:0]; wdata_next = hci.in_byte;
                        end
                        cnt_next = cnt_reg + 8'd1;
                        if (cnt_reg + 8'd1 == len_reg) pstate_next = P_EXEC;
                    end
                end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                    pstate_next = P_IDLE;
                end
            end
            P_EXEC: begin
                pstate_next = P_RESP;
                if (status_reg == 8'd0 && opcode_reg == 8'h03) tx_start = 1'b1;
                if (status_reg == 8'd0 && opcode_reg == 8'h01) begin
                    case (reg_addr_reg)
                        8'd0:  preamble_next       = reg_data_reg;
                        8'd1:  tx_aa_next[7:0]     = reg_data_reg;
                        8'd2:  tx_aa_next[15:8]    = reg_data_reg;
                        8'd3:  tx_aa_next[23:16]   = reg_data_reg;
                        8'd4:  tx_aa_next[31:24]   = reg_data_reg;
                        8'd5:  tx_crc_next[7:0]    = reg_data_reg;
                        8'd6:  tx_crc_next[15:8]   = reg_data_reg;
                        8'd7:  tx_crc_next[23:16]  = reg_data_reg;
                        8'd8:  tx_ch_next          = reg_data_reg[CHW-1:0];
                        8'd9:  rx_aa_next[7:0]     = reg_data_reg;
                        8'd10: rx_aa_next[15:8]    = reg_data_reg;
                        8'd11: rx_aa_next[23:16]   = reg_data_reg;
                        8'd12: rx_aa_next[31:24]   = reg_data_reg;
                        8'd13: rx_ch_next          = reg_data_reg[CHW-1:0];
                        8'd14: rx_crc_next[7:0]    = reg_data_reg;
                        8'd15: rx_crc_next[15:8]   = reg_data_reg;
                        8'd16: rx_crc_next[23:16]  = reg_data_reg;
                        default: status_next       = 8'd4;
                    endcase
                end
            end
            P_RESP:  if (resp_done) pstate_next = P_IDLE;
            default: pstate_next = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate_reg <= P_IDLE;  ostate_reg <= O_IDLE;
            opcode_reg <= '0;  len_reg <= '0;  cnt_reg <= '0;  status_reg <= '0;
            reg_addr_reg <= '0;  reg_data_reg <= '0;  timer_reg <= '0;  preamble_reg <= '0;
            tx_aa_reg <= '0;  tx_crc_reg <= '0;  tx_ch_reg <= '0;
            rx_aa_reg <= '0;  rx_crc_reg <= '0;  rx_ch_reg <= '0;
            we_reg <= 1'b0;  waddr_reg <= '0;  wdata_reg <= '0;  raddr_reg <= '0;
            obyte_reg <= '0;  oidx_reg <= '0;  osrc_reg <= 1'b0;  oen_reg <= 1'b0;
            pend_reg <= 1'b0;  evt_crc_reg <= 1'b0;  evt_len_reg <= '0;  drop_reg <= '0;
        end else begin
            pstate_reg <= pstate_next;  ostate_reg <= ostate_next;
            opcode_reg <= opcode_next;  len_reg <= len_next;  cnt_reg <= cnt_next;
            status_reg <= status_next;  reg_addr_reg <= reg_addr_next;  reg_data_reg <= reg_data_next;
            timer_reg <= timer_next;  preamble_reg <= preamble_next;
            tx_aa_reg <= tx_aa_next;  tx_crc_reg <= tx_crc_next;  tx_ch_reg <= tx_ch_next;
            rx_aa_reg <= rx_aa_next;  rx_crc_reg <= rx_crc_next;  rx_ch_reg <= rx_ch_next;
            we_reg <= we_next;  waddr_reg <= waddr_next;  wdata_reg <= wdata_next;  raddr_reg <= raddr_next;
            obyte_reg <= obyte_next;  oidx_reg <= oidx_next;  osrc_reg <= osrc_next;  oen_reg <= oen_next;
            pend_reg <= pend_next;  evt_crc_reg <= evt_crc_next;  evt_len_reg <= evt_len_next;
            drop_reg <= drop_next;
        end
    end

    assign hci.out_byte              = obyte_reg;
    assign hci.out_en                = oen_reg;
    assign tx_preamble               = preamble_reg;
    assign tx_access_address         = tx_aa_reg;
    assign tx_crc_state_init_bit     = tx_crc_reg;
    assign tx_channel_number         = tx_ch_reg;
    assign tx_pdu_octet_mem_addr     = waddr_reg;
    assign tx_pdu_octet_mem_data     = wdata_reg;
    assign tx_pdu_octet_mem_we       = we_reg;
    assign rx_unique_bit_sequence    = rx_aa_reg;
    assign rx_channel_number         = rx_ch_reg;
    assign rx_crc_state_init_bit     = rx_crc_reg;
    assign rx_pdu_octet_mem_addr     = raddr_reg;
    assign evt_drop_cnt              = drop_reg;
endmodule

// File: tb/tb_btle_ll_hci.sv
// Scoreboard bench for btle_ll_hci: expected host bytes and PDU writes are queued when
// stimulus is driven and compared as the engine produces them.
module tb_btle_ll_hci;
    localparam int TO = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btle_ll_hci_if hif();

    logic [7:0]  tx_preamble, tx_mem_data, rx_rdata, evt_drop_cnt;
    logic [31:0] tx_aa, rx_aa;
    logic [23:0] tx_crc, rx_crc;
    logic [5:0]  tx_ch, rx_ch, tx_mem_addr, rx_addr;
    logic        tx_we, tx_start;
    logic        rx_decode_end = 1'b0, rx_crc_ok = 1'b0;
    logic [6:0]  rx_payload_length = '0;
    logic [7:0]  rx_mem [64];

    btle_ll_hci #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .hci(hif),
        .tx_preamble(tx_preamble), .tx_access_address(tx_aa), .tx_crc_state_init_bit(tx_crc),
        .tx_channel_number(tx_ch), .tx_pdu_octet_mem_addr(tx_mem_addr),
        .tx_pdu_octet_mem_data(tx_mem_data), .tx_pdu_octet_mem_we(tx_we), .tx_start(tx_start),
        .rx_unique_bit_sequence(rx_aa), .rx_channel_number(rx_ch), .rx_crc_state_init_bit(rx_crc),
        .rx_decode_end(rx_decode_end), .rx_crc_ok(rx_crc_ok), .rx_payload_length(rx_payload_length),
        .rx_pdu_octet_mem_addr(rx_addr), .rx_pdu_octet_mem_data(rx_rdata), .evt_drop_cnt(evt_drop_cnt)
    );

    always @(posedge clk) rx_rdata <= rx_mem[rx_addr];

    int checks = 0, errors = 0, out_seen = 0, ts_cnt = 0;
    logic [7:0]  exp_out [$];
    logic [13:0] exp_wr [$];
    logic [7:0]  out_e;
    logic [13:0] wr_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Host-side byte monitor, PDU write monitor and tx_start counter.
    always @(negedge clk) begin
        if (!rst && hif.out_en) begin
            out_seen++;
            if (exp_out.size() == 0) check("out_unexpected", {24'd0, hif.out_byte}, 32'hFFFF_FFFF);
            else begin
                out_e = exp_out.pop_front();
                check("out_byte", {24'd0, hif.out_byte}, {24'd0, out_e});
            end
        end
        if (!rst && tx_we) begin
            if (exp_wr.size() == 0) check("wr_unexpected", {18'd0, tx_mem_addr, tx_mem_data}, 32'hFFFF_FFFF);
            else begin
                wr_e = exp_wr.pop_front();
                check("wr_addr_data", {18'd0, tx_mem_addr, tx_mem_data}, {18'd0, wr_e});
            end
        end
        if (!rst && tx_start) ts_cnt++;
    end

    // UART transmitter model: acknowledges each byte a few cycles after out_en.
    initial begin
        hif.out_done = 1'b0;
        forever begin
            @(negedge clk);
            if (hif.out_en) begin
                repeat (3) @(negedge clk);
                hif.out_done = 1'b1;
                @(negedge clk);
                hif.out_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        hif.in_byte = b; hif.in_valid = 1'b1;
        @(negedge clk);
        hif.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_err();
        @(negedge clk); hif.in_err = 1'b1;
        @(negedge clk); hif.in_err = 1'b0;
    endtask

    task automatic pulse_rx(input logic crc, input logic [6:0] len, input logic expect_evt);
        if (expect_evt) begin
            exp_out.push_back(8'h3E);
            exp_out.push_back({crc, len});
            for (int i = 0; i < ((len > 7'd64) ? 64 : int'(len)); i++) exp_out.push_back(rx_mem[i]);
        end
        @(negedge clk); rx_decode_end = 1'b1; rx_crc_ok = crc; rx_payload_length = len;
        @(negedge clk); rx_decode_end = 1'b0;
    endtask

    task automatic expect_resp(input logic [7:0] st);
        exp_out.push_back(8'h0E);
        exp_out.push_back(st);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (exp_out.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, exp_out.size(), 0);
        repeat (10) @(negedge clk);
        $display("txn %s: %0d checks, %0d errors so far", tag, checks, errors);
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d, input logic [7:0] st);
        expect_resp(st);
        send_byte(8'h01); send_byte(8'h02); send_byte(a); send_byte(d);
        wait_idle("write_reg");
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_preamble"}, {24'd0, tx_preamble}, 0);
        check({tag, "_tx_aa"}, tx_aa, 0);
        check({tag, "_tx_crc"}, {8'd0, tx_crc}, 0);
        check({tag, "_tx_ch"}, {26'd0, tx_ch}, 0);
        check({tag, "_rx_aa"}, rx_aa, 0);
        check({tag, "_rx_ch_crc"}, {2'd0, rx_ch, rx_crc}, 0);
        check({tag, "_mem_wr"}, {17'd0, tx_we, tx_mem_addr, tx_mem_data}, 0);
        check({tag, "_strobes"}, {30'd0, tx_start, hif.out_en}, 0);
        check({tag, "_out_byte"}, {24'd0, hif.out_byte}, 0);
        check({tag, "_drop_raddr"}, {18'd0, rx_addr, evt_drop_cnt}, 0);
    endtask

    function automatic logic [7:0] regd(input int a);
        return 8'(a * 17 + 5);
    endfunction

    initial begin
        int ts0, seen0;
        hif.in_byte = 8'h00; hif.in_valid = 1'b0; hif.in_err = 1'b0;
        for (int i = 0; i < 64; i++) rx_mem[i] = 8'(i * 7 + 3);
        rx_mem[0] = 8'hAA; rx_mem[1] = 8'hBB;
        repeat (3) @(negedge clk);
        reset_checks("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Register writes
        write_reg(8'h04, 8'h5A, 8'h00);
        check("tx_aa_byte3", tx_aa, 32'h5A00_0000);
        write_reg(8'h03, 8'h12, 8'h00);
        check("tx_aa_byte2", tx_aa, 32'h5A12_0000);
        for (int a = 0; a <= 16; a++) write_reg(8'(a), regd(a), 8'h00);
        check("preamble", {24'd0, tx_preamble}, {24'd0, regd(0)});
        check("tx_aa", tx_aa, {regd(4), regd(3), regd(2), regd(1)});
        check("tx_crc", {8'd0, tx_crc}, {8'd0, regd(7), regd(6), regd(5)});
        check("tx_ch", {26'd0, tx_ch}, {26'd0, regd(8) & 8'h3F});
        check("rx_aa", rx_aa, {regd(12), regd(11), regd(10), regd(9)});
        check("rx_ch", {26'd0, rx_ch}, {26'd0, regd(13) & 8'h3F});
        check("rx_crc", {8'd0, rx_crc}, {8'd0, regd(16), regd(15), regd(14)});
        write_reg(8'h11, 8'h99, 8'h04);
        write_reg(8'h20, 8'h99, 8'h04);
        check("bad_addr_nochange", {24'd0, tx_preamble}, {24'd0, regd(0)});
        expect_resp(8'h02);
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
        wait_idle("write_reg_badlen");

        // PDU writes, including empty and oversize lengths
        ts0 = ts_cnt;
        exp_wr.push_back({6'd0, 8'h11}); exp_wr.push_back({6'd1, 8'h22}); exp_wr.push_back({6'd2, 8'h33});
        expect_resp(8'h00);
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        wait_idle("write_pdu3");
        check("pdu_no_tx_start", ts_cnt, ts0);
        expect_resp(8'h00);
        send_byte(8'h02); send_byte(8'd64);
        for (int i = 0; i < 64; i++) begin
            exp_wr.push_back({6'(i), 8'(i) ^ 8'h3C});
            send_byte(8'(i) ^ 8'h3C);
        end
        wait_idle("write_pdu64");
        expect_resp(8'h02);
        send_byte(8'h02); send_byte(8'd65);
        for (int i = 0; i < 65; i++) send_byte(8'hE0);
        wait_idle("write_pdu65");
        expect_resp(8'h02);
        send_byte(8'h02); send_byte(8'h00);
        wait_idle("write_pdu0");
        check("pdu_queue_empty", exp_wr.size(), 0);

        // TX start and unknown opcode
        ts0 = ts_cnt;
        expect_resp(8'h00);
        send_byte(8'h03); send_byte(8'h00);
        wait_idle("tx_start");
        check("tx_start_once", ts_cnt, ts0 + 1);
        expect_resp(8'h02);
        send_byte(8'h03); send_byte(8'h01); send_byte(8'h77);
        wait_idle("tx_start_badlen");
        check("tx_start_badlen", ts_cnt, ts0 + 1);
        expect_resp(8'h01);
        send_byte(8'h07); send_byte(8'h00);
        wait_idle("unknown_op");

        // RX events: normal, dropped mid-stream, clamped length
        pulse_rx(1'b1, 7'd2, 1'b1);
        repeat (6) @(negedge clk);
        pulse_rx(1'b1, 7'd2, 1'b0);
        wait_idle("rx_event");
        check("drop_cnt", {24'd0, evt_drop_cnt}, 1);
        pulse_rx(1'b0, 7'd100, 1'b1);
        wait_idle("rx_event_clamp");

        // Timeout mid-packet, framing errors
        seen0 = out_seen;
        send_byte(8'h01); send_byte(8'h02);
        repeat (TO + 20) @(negedge clk);
        check("timeout_quiet", out_seen, seen0);
        ts0 = ts_cnt;
        expect_resp(8'h00);
        send_byte(8'h03); send_byte(8'h00);
        wait_idle("after_timeout");
        check("after_timeout_start", ts_cnt, ts0 + 1);
        expect_resp(8'h03);
        send_byte(8'h01);
        pulse_err();
        wait_idle("frame_err");
        pulse_err();
        expect_resp(8'h00);
        send_byte(8'h03); send_byte(8'h00);
        wait_idle("idle_err_ignored");

        // Reset in the middle of a PDU write
        exp_wr.push_back({6'd0, 8'hAA}); exp_wr.push_back({6'd1, 8'hBB});
        send_byte(8'h02); send_byte(8'h04); send_byte(8'hAA); send_byte(8'hBB);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        reset_checks("midrst");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        write_reg(8'h01, 8'h77, 8'h00);
        check("post_reset_tx_aa", tx_aa, 32'h0000_0077);

        check("final_out_queue", exp_out.size(), 0);
        check("final_wr_queue", exp_wr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
